// File: rtl/lieat_idu_scoreboard.sv
// Outstanding-instruction scoreboard: per-class circular queues (common, LSU, MUL/DIV) with hazard lookup.
// Optional macro LIEAT_SB_WBCK_BYPASS_EN hides the entry retiring this cycle from disp_dep/ifu_dep.
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_sb_class #(
    parameter int DEPTH = 1,
    parameter int RW    = 5,
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          disp,
    input  logic          ret,
    input  logic          flush,
    input  logic          rs1en,
    input  logic          rs2en,
    input  logic          rdwen,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic [RW-1:0] wb_rd,
    input  logic [RW-1:0] jalr_rs1,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          disp_hit,
    output logic          wbck_hit,
    output logic          ifu_hit
);
`ifdef LIEAT_SB_WBCK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    // Depth 1 never advances its pointers, so the single entry stays at index 0.
    localparam logic [PW-1:0] STEP = PW'(DEPTH > 1);

    logic [DEPTH-1:0] vld, wen;
    logic [RW-1:0]    rd_q [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             do_disp, do_ret;

    assign full    = (cnt == CW'(DEPTH));
    assign do_disp = disp & ~full & ~flush;
    assign do_ret  = ret & (cnt != '0) & ~flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld  <= '0;
            wen  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            vld  <= '0;
            rptr <= wptr;
            cnt  <= '0;
        end else begin
            if (do_ret) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + STEP;
            end
            if (do_disp) begin
                vld[wptr] <= 1'b1;
                wen[wptr] <= rdwen;
                wptr      <= wptr + STEP;
            end
            cnt <= cnt + CW'(do_disp) - CW'(do_ret);
        end
    end

    // Register indices are only meaningful under vld, so they need no reset.
    always_ff @(posedge clock) begin
        if (do_disp) rd_q[wptr] <= rd;
    end

    always_comb begin
        disp_hit = 1'b0;
        wbck_hit = 1'b0;
        ifu_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && wen[i]) begin
                if (rd_q[i] == wb_rd) wbck_hit = 1'b1;
                if (!(BYP && do_ret && rptr == PW'(i))) begin
                    if (rd_q[i] == jalr_rs1) ifu_hit = 1'b1;
                    if ((rs1en && rd_q[i] == rs1) || (rs2en && rd_q[i] == rs2) ||
                        (rdwen && rd_q[i] == rd))
                        disp_hit = 1'b1;
                end
            end
        end
    end
endmodule

module lieat_idu_scoreboard #(
    parameter int COM_DEPTH = 2,
    parameter int LSU_DEPTH = 1,
    parameter int MD_DEPTH  = 1,
    localparam int RW  = `REG_IDX,
    localparam int CCW = $clog2(COM_DEPTH) + 1,
    localparam int LCW = $clog2(LSU_DEPTH) + 1,
    localparam int MCW = $clog2(MD_DEPTH) + 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           disp_ena,
    input  logic [2:0]     disp_op,
    input  logic           disp_rs1en,
    input  logic           disp_rs2en,
    input  logic           disp_rdwen,
    input  logic [RW-1:0]  disp_rs1,
    input  logic [RW-1:0]  disp_rs2,
    input  logic [RW-1:0]  disp_rd,
    input  logic           wbck_ena,
    input  logic [2:0]     wbck_op,
    input  logic [2:0]     flush,
    input  logic [RW-1:0]  ifu_jalr_rs1,
    input  logic [RW-1:0]  wbu_dep_rd,
    output logic           disp_dep,
    output logic           wbck_dep,
    output logic           ifu_dep,
    output logic           oitf_full,
    output logic           longi_empty,
    output logic           all_empty,
    output logic [CCW-1:0] com_cnt,
    output logic [LCW-1:0] lsu_cnt,
    output logic [MCW-1:0] md_cnt,
    output logic           err_ovf,
    output logic           err_unf
);
    logic [2:0] cls, cls_disp, cls_ret, full_v, empty_v, dhit, whit, ihit;
    logic       wb_onehot, ovf_ev, unf_ev;

    // Bit order everywhere: [0] common, [1] LSU, [2] MUL/DIV.
    assign cls[1]    = (disp_op == 3'b010);
    assign cls[2]    = (disp_op == 3'b100);
    assign cls[0]    = ~cls[1] & ~cls[2];
    assign cls_disp  = {3{disp_ena}} & cls;
    assign wb_onehot = $onehot(wbck_op);
    assign cls_ret   = {3{wbck_ena & wb_onehot}} & wbck_op;
    assign empty_v   = {md_cnt == '0, lsu_cnt == '0, com_cnt == '0};

    assign ovf_ev = |(cls_disp & full_v);
    assign unf_ev = wbck_ena & (~wb_onehot | |(cls_ret & empty_v));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (ovf_ev) err_ovf <= 1'b1;
            if (unf_ev) err_unf <= 1'b1;
        end
    end

    lieat_sb_class #(.DEPTH(COM_DEPTH), .RW(RW)) u_com (
        .clock(clock), .reset(reset), .disp(cls_disp[0]), .ret(cls_ret[0]), .flush(flush[0]),
        .rs1en(disp_rs1en), .rs2en(disp_rs2en), .rdwen(disp_rdwen),
        .rs1(disp_rs1), .rs2(disp_rs2), .rd(disp_rd), .wb_rd(wbu_dep_rd), .jalr_rs1(ifu_jalr_rs1),
        .cnt(com_cnt), .full(full_v[0]), .disp_hit(dhit[0]), .wbck_hit(whit[0]), .ifu_hit(ihit[0]));

    lieat_sb_class #(.DEPTH(LSU_DEPTH), .RW(RW)) u_lsu (
        .clock(clock), .reset(reset), .disp(cls_disp[1]), .ret(cls_ret[1]), .flush(flush[1]),
        .rs1en(disp_rs1en), .rs2en(disp_rs2en), .rdwen(disp_rdwen),
        .rs1(disp_rs1), .rs2(disp_rs2), .rd(disp_rd), .wb_rd(wbu_dep_rd), .jalr_rs1(ifu_jalr_rs1),
        .cnt(lsu_cnt), .full(full_v[1]), .disp_hit(dhit[1]), .wbck_hit(whit[1]), .ifu_hit(ihit[1]));

    lieat_sb_class #(.DEPTH(MD_DEPTH), .RW(RW)) u_md (
        .clock(clock), .reset(reset), .disp(cls_disp[2]), .ret(cls_ret[2]), .flush(flush[2]),
        .rs1en(disp_rs1en), .rs2en(disp_rs2en), .rdwen(disp_rdwen),
        .rs1(disp_rs1), .rs2(disp_rs2), .rd(disp_rd), .wb_rd(wbu_dep_rd), .jalr_rs1(ifu_jalr_rs1),
        .cnt(md_cnt), .full(full_v[2]), .disp_hit(dhit[2]), .wbck_hit(whit[2]), .ifu_hit(ihit[2]));

    assign disp_dep    = |dhit;
    assign wbck_dep    = |whit;
    assign ifu_dep     = |ihit;
    assign oitf_full   = |(cls & full_v);
    assign longi_empty = empty_v[1] & empty_v[2];
    assign all_empty   = &empty_v;
endmodule
